// File: rtl/path_sensor_pkg.sv
// Shared encodings for the path-sensor controller: FSM states, motor codes,
// colour ids and TCS3200 filter selects.
package path_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_RIGHT  = 3'd3,
    ST_SEARCH = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  typedef enum logic {
    SIDE_RIGHT = 1'b0,
    SIDE_LEFT  = 1'b1
  } side_t;

  typedef enum logic [1:0] {
    COL_NONE  = 2'b00,
    COL_RED   = 2'b01,
    COL_GREEN = 2'b10,
    COL_BLUE  = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    FLT_RED   = 2'b00,
    FLT_GREEN = 2'b11,
    FLT_BLUE  = 2'b01
  } filter_t;

  localparam logic [3:0] MOT_OFF   = 4'b0000;
  localparam logic [3:0] MOT_FWD   = 4'b1010;
  localparam logic [3:0] MOT_LEFT  = 4'b0110;
  localparam logic [3:0] MOT_RIGHT = 4'b1001;
  localparam logic [1:0] SCALE_20  = 2'b10;

  // SEARCH pivots towards the side the line was last seen on
  function automatic logic [3:0] motor_code(input state_t s, input side_t side);
    logic [3:0] code;
    case (s)
      ST_FWD:    code = MOT_FWD;
      ST_LEFT:   code = MOT_LEFT;
      ST_RIGHT:  code = MOT_RIGHT;
      ST_SEARCH: code = (side == SIDE_LEFT) ? MOT_LEFT : MOT_RIGHT;
      default:   code = MOT_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/color_freq_meter.sv
// TCS3200 frequency meter: cycles R/G/B filters, counts rising edges per
// window with saturation and classifies the dominant colour after BLUE.
module color_freq_meter
  import path_sensor_pkg::*;
#(
  parameter int unsigned COLOR_WIN = 100000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_CNT   = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_freq,
  output logic [3:0] o_color_s,
  output logic [1:0] o_color_id,
  output logic       o_color_valid
);

  localparam int unsigned WIN_W = $clog2(COLOR_WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(COLOR_WIN - 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_CNT);

  logic [2:0]       r_sync;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_cnt, r_cnt_r, r_cnt_g;
  filter_t          r_filt;
  logic [1:0]       r_id;
  logic             r_valid;

  logic             w_edge, w_win_end;
  logic [CNT_W-1:0] w_cnt_inc, w_max;
  color_t           w_class;

  assign w_edge    = r_sync[1] & ~r_sync[2];
  assign w_win_end = (r_win == WIN_LAST);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // r_cnt holds the BLUE count while the last BLUE cycle is being classified
  always_comb begin
    w_max   = r_cnt_r;
    w_class = COL_RED;
    if (r_cnt_r >= r_cnt_g && r_cnt_r >= r_cnt) begin
      w_max   = r_cnt_r;
      w_class = COL_RED;
    end else if (r_cnt_g >= r_cnt) begin
      w_max   = r_cnt_g;
      w_class = COL_GREEN;
    end else begin
      w_max   = r_cnt;
      w_class = COL_BLUE;
    end
    if (w_max < MIN_C) w_class = COL_NONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_filt  <= FLT_RED;
      r_id    <= COL_NONE;
      r_valid <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_freq};
      r_valid <= 1'b0;
      if (w_win_end) begin
        r_win <= '0;
        r_cnt <= CNT_W'(w_edge);
        case (r_filt)
          FLT_RED: begin
            r_cnt_r <= r_cnt;
            r_filt  <= FLT_GREEN;
          end
          FLT_GREEN: begin
            r_cnt_g <= r_cnt;
            r_filt  <= FLT_BLUE;
          end
          default: begin
            r_filt  <= FLT_RED;
            r_id    <= w_class;
            r_valid <= 1'b1;
          end
        endcase
      end else begin
        r_win <= r_win + 1'b1;
        if (w_edge) r_cnt <= w_cnt_inc;
      end
    end
  end

  assign o_color_s     = {SCALE_20, r_filt};
  assign o_color_id    = r_id;
  assign o_color_valid = r_valid;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following car controller: synchronises and debounces sensors, steers
// with a registered FSM, drives L298 PWM, and stops on obstacle or red marker.
module line_follow_ctrl
  import path_sensor_pkg::*;
#(
  parameter int unsigned NUM_LINE     = 3,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned COLOR_WIN    = 100000,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MIN_CNT      = 50,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned SPEED_FWD    = 200,
  parameter int unsigned SPEED_TURN   = 120,
  parameter int unsigned STOP_ON_RED  = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_LINE-1:0] line_in,
  input  logic                object_in,
  input  logic                color_freq,
  output logic [3:0]          color_s,
  output logic [3:0]          in,
  output logic                en_a,
  output logic                en_b,
  output logic [3:0]          led,
  output logic [1:0]          color_id,
  output logic                color_valid
);

  localparam int unsigned NB   = NUM_LINE + 1;
  localparam int unsigned CTR  = NUM_LINE / 2;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PWM_W-1:0] DUTY_FWD  = PWM_W'(SPEED_FWD);
  localparam logic [PWM_W-1:0] DUTY_TURN = PWM_W'(SPEED_TURN);

  logic [NB-1:0]    r_s1, r_s2, r_flt;
  logic [DB_W-1:0]  r_db [NB];
  state_t           r_state;
  side_t            r_side;
  logic [3:0]       r_in;
  logic             r_led_stop, r_led_search, r_red_stop;
  logic [PWM_W-1:0] r_pwm_cnt, r_duty;

  logic [NUM_LINE-1:0] w_line_f;
  logic                w_obj_f, w_c, w_lft, w_rgt, w_run;
  state_t              w_dec, w_next;
  side_t               w_side_next;
  logic [PWM_W-1:0]    w_duty_tgt;
  logic [1:0]          w_col_id;
  logic                w_col_valid;

  color_freq_meter #(
    .COLOR_WIN (COLOR_WIN),
    .CNT_W     (CNT_W),
    .MIN_CNT   (MIN_CNT)
  ) u_meter (
    .i_clk         (clock),
    .i_rst_n       (reset_n),
    .i_freq        (color_freq),
    .o_color_s     (color_s),
    .o_color_id    (w_col_id),
    .o_color_valid (w_col_valid)
  );

  // Filtered bit flips on the DEBOUNCE_CYC-th consecutive differing cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_flt <= '0;
      for (int unsigned i = 0; i < NB; i++) r_db[i] <= '0;
    end else begin
      r_s1 <= {object_in, line_in};
      r_s2 <= r_s1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_s2[i] == r_flt[i]) begin
          r_db[i] <= '0;
        end else if (r_db[i] == DB_LAST) begin
          r_flt[i] <= r_s2[i];
          r_db[i]  <= '0;
        end else begin
          r_db[i] <= r_db[i] + 1'b1;
        end
      end
    end
  end

  assign w_line_f = r_flt[NUM_LINE-1:0];
  assign w_obj_f  = r_flt[NUM_LINE];
  assign w_c      = w_line_f[CTR];
  assign w_lft    = |w_line_f[NUM_LINE-1:CTR+1];
  assign w_rgt    = |w_line_f[CTR-1:0];

  always_comb begin
    w_dec = ST_SEARCH;
    if (w_c || (w_lft && w_rgt)) w_dec = ST_FWD;
    else if (w_lft)              w_dec = ST_LEFT;
    else if (w_rgt)              w_dec = ST_RIGHT;

    w_next = w_dec;
    if (w_obj_f || r_red_stop) w_next = ST_STOP;
    else if (r_state == ST_IDLE) w_next = ST_FWD;

    w_side_next = r_side;
    if (w_next == ST_LEFT)       w_side_next = SIDE_LEFT;
    else if (w_next == ST_RIGHT) w_side_next = SIDE_RIGHT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_side       <= SIDE_RIGHT;
      r_in         <= MOT_OFF;
      r_led_stop   <= 1'b0;
      r_led_search <= 1'b0;
      r_red_stop   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_side       <= w_side_next;
      r_in         <= motor_code(w_next, w_side_next);
      r_led_stop   <= (w_next == ST_STOP);
      r_led_search <= (w_next == ST_SEARCH);
      if (w_col_valid)
        r_red_stop <= (STOP_ON_RED != 0) && (w_col_id == COL_RED);
    end
  end

  always_comb begin
    case (r_state)
      ST_FWD:                       w_duty_tgt = DUTY_FWD;
      ST_LEFT, ST_RIGHT, ST_SEARCH: w_duty_tgt = DUTY_TURN;
      default:                      w_duty_tgt = '0;
    endcase
  end

  // Duty is latched only at the wrap; STOP/IDLE gate the enables immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) r_duty <= w_duty_tgt;
    end
  end

  assign w_run       = (r_state != ST_STOP) && (r_state != ST_IDLE);
  assign en_a        = w_run && (r_pwm_cnt < r_duty);
  assign en_b        = w_run && (r_pwm_cnt < r_duty);
  assign in          = r_in;
  assign led         = {r_led_stop, r_led_search, w_col_id};
  assign color_id    = w_col_id;
  assign color_valid = w_col_valid;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: expected motor/led changes and colour
// classifications are queued by stimulus and popped by independent monitors.
module tb_line_follow_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, rst8_n;
  logic [2:0] line_in;
  logic       object_in, color_freq, color_freq8;
  logic [3:0] color_s, mot, led;
  logic       en_a, en_b, color_valid;
  logic [1:0] color_id;
  logic [3:0] color_s8, mot8, led8;
  logic       en_a8, en_b8, color_valid8;
  logic [1:0] color_id8;

  line_follow_ctrl #(
    .NUM_LINE(3), .DEBOUNCE_CYC(4), .COLOR_WIN(1000), .CNT_W(16), .MIN_CNT(50),
    .PWM_W(8), .SPEED_FWD(200), .SPEED_TURN(120), .STOP_ON_RED(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .line_in(line_in), .object_in(object_in),
    .color_freq(color_freq), .color_s(color_s), .in(mot), .en_a(en_a), .en_b(en_b),
    .led(led), .color_id(color_id), .color_valid(color_valid)
  );

  line_follow_ctrl #(
    .NUM_LINE(3), .DEBOUNCE_CYC(4), .COLOR_WIN(1000), .CNT_W(8), .MIN_CNT(50),
    .PWM_W(8), .SPEED_FWD(200), .SPEED_TURN(120), .STOP_ON_RED(1)
  ) dut8 (
    .clock(clock), .reset_n(rst8_n), .line_in(3'b000), .object_in(1'b0),
    .color_freq(color_freq8), .color_s(color_s8), .in(mot8), .en_a(en_a8), .en_b(en_b8),
    .led(led8), .color_id(color_id8), .color_valid(color_valid8)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] q_mot[$];
  logic [1:0] q_col[$];
  int mode  = 0;
  int mode8 = 1;
  bit done8 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Frequency sources follow whichever filter the DUT currently selects
  initial begin
    int ph, per, per8;
    ph = 0;
    color_freq  = 1'b0;
    color_freq8 = 1'b0;
    forever begin
      @(negedge clock);
      ph++;
      per = 0;
      if (mode == 1) per = (color_s[1:0] == 2'b00) ? 10 : 40;
      if (mode == 2) per = (color_s[1:0] == 2'b11) ? 10 : 40;
      per8 = 0;
      if (mode8 == 1) per8 = (color_s8[1:0] == 2'b00) ? 2 : (color_s8[1:0] == 2'b11) ? 4 : 0;
      color_freq  = (per  != 0) && ((ph % per)  < per / 2);
      color_freq8 = (per8 != 0) && ((ph % per8) < per8 / 2);
    end
  end

  // Motor/led monitor: every change of {in, stop, search} must match the queue head
  initial begin
    logic [5:0] prev, cur, exp;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = {mot, led[3], led[2]};
      if (cur !== prev) begin
        checks++;
        if (q_mot.size() == 0) begin
          errors++;
          $display("FAIL motor_unexpected got=%b", cur);
        end else begin
          exp = q_mot.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL motor_change got=%b exp=%b", cur, exp);
          end
        end
        prev = cur;
      end
    end
  end

  // Colour monitor: pulse spacing and classification; idle input implies NONE
  initial begin
    int ccyc;
    logic [1:0] exp;
    ccyc = 0;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        ccyc = 0;
      end else begin
        ccyc++;
        #1;
        if (color_valid) begin
          chk("color_interval", ccyc, 3000);
          exp = (q_col.size() != 0) ? q_col.pop_front() : 2'b00;
          checks++;
          if (color_id !== exp || led[1:0] !== exp) begin
            errors++;
            $display("FAIL color_id got=%b led=%b exp=%b", color_id, led[1:0], exp);
          end
          ccyc = 0;
        end
      end
    end
  end

  // Saturation instance: R saturates at 255 and must beat G=~250
  initial begin
    bit seen;
    seen = 1'b0;
    @(posedge rst8_n);
    for (int i = 0; i < 3100 && !seen; i++) begin
      @(negedge clock);
      if (color_valid8) seen = 1'b1;
    end
    chk("sat_valid_seen", int'(seen), 1);
    chk("sat_color_id", int'(color_id8), 1);
    mode8 = 0;
    done8 = 1'b1;
  end

  task automatic wait_drain(input int maxc, input string nm);
    for (int i = 0; i < maxc && q_mot.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    chk(nm, q_mot.size(), 0);
    q_mot.delete();
  endtask

  task automatic measure(input int exp, input string nm);
    int ca, cb;
    ca = 0;
    cb = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      ca += int'(en_a);
      cb += int'(en_b);
    end
    chk({nm, "_en_a"}, ca, exp);
    chk({nm, "_en_b"}, cb, exp);
  endtask

  task automatic wait_valid(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clock);
      if (color_valid) seen = 1'b1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic push_startup();
    q_mot.push_back({4'b1010, 2'b00});
    q_mot.push_back({4'b1001, 2'b01});
    q_mot.push_back({4'b1010, 2'b00});
  endtask

  initial begin
    int ca;
    reset_n   = 1'b0;
    rst8_n    = 1'b0;
    line_in   = 3'b010;
    object_in = 1'b0;
    repeat (3) @(negedge clock);
    push_startup();
    reset_n = 1'b1;
    rst8_n  = 1'b1;
    wait_drain(12, "startup_fwd");

    repeat (40) @(negedge clock);
    q_mot.push_back(6'b000000);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in", int'(mot), 0);
    chk("rst_en", int'({en_a, en_b}), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_color_s", int'(color_s), 8);
    chk("rst_color", int'({color_id, color_valid}), 0);
    repeat (3) @(negedge clock);
    push_startup();
    reset_n = 1'b1;
    wait_drain(12, "rerelease_fwd");

    repeat (600) @(negedge clock);
    measure(200, "duty_fwd");

    q_mot.push_back({4'b0110, 2'b00});
    line_in = 3'b100;
    wait_drain(12, "left");
    repeat (520) @(negedge clock);
    measure(120, "duty_left");

    q_mot.push_back({4'b0110, 2'b01});
    line_in = 3'b000;
    wait_drain(12, "search_left");

    q_mot.push_back({4'b1001, 2'b00});
    line_in = 3'b001;
    wait_drain(12, "right");

    q_mot.push_back({4'b1010, 2'b00});
    line_in = 3'b010;
    wait_drain(12, "fwd_again");
    line_in = 3'b100;
    repeat (3) @(negedge clock);
    line_in = 3'b010;
    repeat (20) @(negedge clock);
    chk("glitch_held_fwd", int'(mot), 4'b1010);
    q_mot.push_back({4'b0110, 2'b00});
    line_in = 3'b100;
    wait_drain(12, "debounced_left");

    q_mot.push_back({4'b0000, 2'b10});
    object_in = 1'b1;
    wait_drain(12, "obstacle_stop");
    ca = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      ca += int'(en_a) + int'(en_b);
    end
    chk("obstacle_en_off", ca, 0);
    q_mot.push_back({4'b0110, 2'b00});
    object_in = 1'b0;
    wait_drain(12, "obstacle_clear");

    q_mot.push_back({4'b1010, 2'b00});
    line_in = 3'b010;
    wait_drain(12, "fwd_for_color");

    wait_valid(3100, "scan_align");
    q_col.push_back(2'b01);
    q_mot.push_back({4'b0000, 2'b10});
    mode = 1;
    wait_valid(3100, "scan_red");
    q_col.push_back(2'b10);
    q_mot.push_back({4'b1010, 2'b00});
    mode = 2;
    wait_valid(3100, "scan_green");
    q_col.push_back(2'b00);
    mode = 0;
    wait_valid(3100, "scan_none");
    wait_drain(12, "color_motor");
    repeat (3) @(negedge clock);
    chk("color_queue_empty", q_col.size(), 0);
    chk("sat_done", int'(done8), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
